// File: rtl/wb_byte_master_if.sv
// Wishbone bus bundle between the byte master and a 32-bit slave.
//   wb_adr_o  word address           wb_dat_o  write data (byte replicated)
//   wb_dat_i  read data              wb_sel_o  one-hot byte select
//   wb_we_o   write enable           wb_stb_o  strobe
//   wb_cyc_o  cycle                  wb_ack_i  acknowledge
interface wb_byte_master_if #(
    parameter int unsigned aw = 15
) ();
    logic [aw-1:0] wb_adr_o;
    logic [31:0]   wb_dat_o;
    logic [31:0]   wb_dat_i;
    logic [3:0]    wb_sel_o;
    logic          wb_we_o;
    logic          wb_stb_o;
    logic          wb_cyc_o;
    logic          wb_ack_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/wb_byte_master.sv
// Byte-wide CPU request port bridged onto a 32-bit Wishbone master with
// a strobe timeout. One transfer at a time: IDLE -> BUS -> DONE -> IDLE.
//   clk_i, rst_i     clock, synchronous active-high reset
//   cpu_req_i        start a transfer (sampled only while not busy)
//   cpu_we_i         1 = write, 0 = read
//   cpu_adr_i        byte address
//   cpu_dat_i        write byte
//   cpu_dat_o        last read byte (0xFF after a read timeout)
//   cpu_busy_o       transfer in progress
//   cpu_done_o       one-cycle completion pulse
//   cpu_err_o        one-cycle timeout pulse, coincident with cpu_done_o
//   wb               Wishbone master modport
module wb_byte_master #(
    parameter int unsigned aw      = 15,
    parameter int unsigned timeout = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [aw-1:0] cpu_adr_i,
    input  logic [7:0]    cpu_dat_i,
    output logic [7:0]    cpu_dat_o,
    output logic          cpu_busy_o,
    output logic          cpu_done_o,
    output logic          cpu_err_o,
    wb_byte_master_if.master wb
);

    localparam int unsigned cnt_w = 8;
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(timeout - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [cnt_w-1:0] cnt_q,    cnt_d;
    logic [1:0]       lane_q,   lane_d;
    logic [aw-1:0]    adr_q,    adr_d;
    logic [3:0]       sel_q,    sel_d;
    logic [31:0]      wdat_q,   wdat_d;
    logic             we_q,     we_d;
    logic             cyc_q,    cyc_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             err_q,    err_d;
    logic [7:0]       rdat_q,   rdat_d;
    logic [7:0]       lane_byte;

    // Byte lane of the read data addressed by the latched adr[1:0]
    always_comb begin
        lane_byte = wb.wb_dat_i[7:0];
        case (lane_q)
            2'd0: lane_byte = wb.wb_dat_i[7:0];
            2'd1: lane_byte = wb.wb_dat_i[15:8];
            2'd2: lane_byte = wb.wb_dat_i[23:16];
            2'd3: lane_byte = wb.wb_dat_i[31:24];
            default: lane_byte = wb.wb_dat_i[7:0];
        endcase
    end

    // Next-state and next-output logic; every output is registered from here
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdat_d  = rdat_q;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req_i) begin
                    state_d = ST_BUS;
                    cnt_d   = '0;
                    lane_d  = cpu_adr_i[1:0];
                    adr_d   = {cpu_adr_i[aw-1:2], 2'b00};
                    sel_d   = 4'b0001 << cpu_adr_i[1:0];
                    wdat_d  = {4{cpu_dat_i}};
                    we_d    = cpu_we_i;
                    cyc_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_BUS: begin
                // Ack is checked first so it wins over a coincident timeout
                if (wb.wb_ack_i) begin
                    state_d = ST_DONE;
                    cyc_d   = 1'b0;
                    done_d  = 1'b1;
                    if (!we_q) rdat_d = lane_byte;
                end else if (cnt_q == cnt_last) begin
                    state_d = ST_DONE;
                    cyc_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    if (!we_q) rdat_d = 8'hFF;
                end else begin
                    cnt_d = cnt_q + cnt_w'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lane_q  <= 2'd0;
            adr_q   <= '0;
            sel_q   <= 4'b0001;
            wdat_q  <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
        end
    end

    assign wb.wb_adr_o = adr_q;
    assign wb.wb_sel_o = sel_q;
    assign wb.wb_dat_o = wdat_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = cyc_q;
    assign cpu_dat_o   = rdat_q;
    assign cpu_busy_o  = busy_q;
    assign cpu_done_o  = done_q;
    assign cpu_err_o   = err_q;

endmodule

// File: tb/tb_wb_byte_master.sv
// Directed bench for wb_byte_master with a small Wishbone slave model.
module tb_wb_byte_master;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cpu_req_i;
    logic        cpu_we_i;
    logic [14:0] cpu_adr_i;
    logic [7:0]  cpu_dat_i;
    logic [7:0]  cpu_dat_o;
    logic        cpu_busy_o;
    logic        cpu_done_o;
    logic        cpu_err_o;

    int tests = 0;
    int fails = 0;

    // Slave behaviour: 0 = registered ack, 1 = never ack, 2 = ack on 16th strobe cycle
    int   slave_mode = 0;
    int   stb_run    = 0;

    wb_byte_master_if #(.aw(15)) wb_if ();

    wb_byte_master #(.aw(15), .timeout(16)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cpu_req_i  (cpu_req_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_adr_i  (cpu_adr_i),
        .cpu_dat_i  (cpu_dat_i),
        .cpu_dat_o  (cpu_dat_o),
        .cpu_busy_o (cpu_busy_o),
        .cpu_done_o (cpu_done_o),
        .cpu_err_o  (cpu_err_o),
        .wb         (wb_if)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (rst_i) begin
            wb_if.wb_ack_i <= 1'b0;
            stb_run        <= 0;
        end else begin
            stb_run <= wb_if.wb_stb_o ? stb_run + 1 : 0;
            case (slave_mode)
                0:       wb_if.wb_ack_i <= wb_if.wb_cyc_o & wb_if.wb_stb_o & ~wb_if.wb_ack_i;
                2:       wb_if.wb_ack_i <= wb_if.wb_cyc_o & wb_if.wb_stb_o & (stb_run == 14);
                default: wb_if.wb_ack_i <= 1'b0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Watch a fixed window of cycles, counting strobe cycles and done/err pulses
    task automatic observe(input int ncyc, output int stb_n, output int done_n, output int err_n,
                           output logic err_at_done, output logic [7:0] dat_at_done);
        stb_n       = wb_if.wb_stb_o ? 1 : 0;
        done_n      = 0;
        err_n       = 0;
        err_at_done = 1'bx;
        dat_at_done = 8'hxx;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk_i);
            if (wb_if.wb_stb_o) stb_n++;
            if (cpu_err_o) err_n++;
            if (cpu_done_o) begin
                done_n++;
                err_at_done = cpu_err_o;
                dat_at_done = cpu_dat_o;
            end
        end
    endtask

    // Present a request for one cycle; returns at the first BUS cycle
    task automatic issue(input logic we, input logic [14:0] adr, input logic [7:0] dat);
        cpu_req_i = 1'b1;
        cpu_we_i  = we;
        cpu_adr_i = adr;
        cpu_dat_i = dat;
        @(negedge clk_i);
        cpu_req_i = 1'b0;
    endtask

    initial begin
        int         stb_n, done_n, err_n;
        logic       err_d;
        logic [7:0] dat_d;
        int         acc_t[$];
        int         min_low;
        int         low_run;
        logic       busy_prev;
        logic       seen_stb;

        rst_i          = 1'b1;
        cpu_req_i      = 1'b0;
        cpu_we_i       = 1'b0;
        cpu_adr_i      = '0;
        cpu_dat_i      = '0;
        wb_if.wb_dat_i = 32'h0;
        repeat (2) @(negedge clk_i);

        // Reset state
        chk("rst_busy", 32'(cpu_busy_o), 32'h0);
        chk("rst_done", 32'(cpu_done_o), 32'h0);
        chk("rst_err",  32'(cpu_err_o),  32'h0);
        chk("rst_cyc",  32'(wb_if.wb_cyc_o), 32'h0);
        chk("rst_stb",  32'(wb_if.wb_stb_o), 32'h0);
        chk("rst_we",   32'(wb_if.wb_we_o),  32'h0);
        chk("rst_cdat", 32'(cpu_dat_o), 32'h0);
        chk("rst_adr",  32'(wb_if.wb_adr_o), 32'h0);
        chk("rst_sel",  32'(wb_if.wb_sel_o), 32'h1);
        chk("rst_wdat", wb_if.wb_dat_o, 32'h0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Write adr 0x0007 data 0xA5, registered-ack slave
        slave_mode = 0;
        issue(1'b1, 15'h0007, 8'hA5);
        chk("wr_busy", 32'(cpu_busy_o), 32'h1);
        chk("wr_cyc",  32'(wb_if.wb_cyc_o), 32'h1);
        chk("wr_adr",  32'(wb_if.wb_adr_o), 32'h0004);
        chk("wr_sel",  32'(wb_if.wb_sel_o), 32'h8);
        chk("wr_wdat", wb_if.wb_dat_o, 32'hA5A5A5A5);
        chk("wr_we",   32'(wb_if.wb_we_o), 32'h1);
        observe(6, stb_n, done_n, err_n, err_d, dat_d);
        chk("wr_stb_cycles", 32'(stb_n), 32'd2);
        chk("wr_done_cnt",   32'(done_n), 32'd1);
        chk("wr_err_cnt",    32'(err_n), 32'd0);
        chk("wr_cdat_kept",  32'(cpu_dat_o), 32'h0);

        // Read adr 0x0001, slave returns 0x44332211 -> lane 1
        wb_if.wb_dat_i = 32'h44332211;
        issue(1'b0, 15'h0001, 8'h00);
        chk("rd_sel", 32'(wb_if.wb_sel_o), 32'h2);
        chk("rd_we",  32'(wb_if.wb_we_o), 32'h0);
        chk("rd_adr", 32'(wb_if.wb_adr_o), 32'h0);
        observe(6, stb_n, done_n, err_n, err_d, dat_d);
        chk("rd_stb_cycles", 32'(stb_n), 32'd2);
        chk("rd_done_cnt",   32'(done_n), 32'd1);
        chk("rd_err_cnt",    32'(err_n), 32'd0);
        chk("rd_dat_at_done", 32'(dat_d), 32'h22);
        chk("rd_dat_held",   32'(cpu_dat_o), 32'h22);

        // Read timeout against a silent slave
        slave_mode = 1;
        issue(1'b0, 15'h0002, 8'h00);
        observe(20, stb_n, done_n, err_n, err_d, dat_d);
        chk("to_rd_stb_cycles", 32'(stb_n), 32'd16);
        chk("to_rd_done_cnt",   32'(done_n), 32'd1);
        chk("to_rd_err_cnt",    32'(err_n), 32'd1);
        chk("to_rd_err_at_done", 32'(err_d), 32'h1);
        chk("to_rd_dat",        32'(dat_d), 32'hFF);

        // Write timeout leaves cpu_dat_o alone
        wb_if.wb_dat_i = 32'h0;
        issue(1'b1, 15'h0003, 8'h3C);
        chk("to_wr_sel", 32'(wb_if.wb_sel_o), 32'h8);
        observe(20, stb_n, done_n, err_n, err_d, dat_d);
        chk("to_wr_stb_cycles", 32'(stb_n), 32'd16);
        chk("to_wr_err_at_done", 32'(err_d), 32'h1);
        chk("to_wr_cdat_kept",  32'(cpu_dat_o), 32'hFF);

        // Back-to-back reads with request held high
        slave_mode     = 0;
        wb_if.wb_dat_i = 32'hDDCCBBAA;
        cpu_req_i      = 1'b1;
        cpu_we_i       = 1'b0;
        cpu_adr_i      = 15'h0005;
        busy_prev      = cpu_busy_o;
        seen_stb       = 1'b0;
        low_run        = 0;
        min_low        = 1000;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk_i);
            if (cpu_busy_o && !busy_prev) acc_t.push_back(i);
            busy_prev = cpu_busy_o;
            if (wb_if.wb_stb_o) begin
                if (seen_stb && low_run > 0 && low_run < min_low) min_low = low_run;
                seen_stb = 1'b1;
                low_run  = 0;
            end else begin
                low_run++;
            end
        end
        cpu_req_i = 1'b0;
        chk("b2b_accepts", 32'(acc_t.size()), 32'd3);
        if (acc_t.size() == 3) begin
            chk("b2b_gap1", 32'(acc_t[1] - acc_t[0]), 32'd4);
            chk("b2b_gap2", 32'(acc_t[2] - acc_t[1]), 32'd4);
        end
        chk("b2b_min_idle", 32'(min_low), 32'd2);
        repeat (6) @(negedge clk_i);
        chk("b2b_idle_after", 32'(cpu_busy_o), 32'h0);
        chk("b2b_dat", 32'(cpu_dat_o), 32'hBB);

        // Reset asserted during the second BUS cycle
        slave_mode = 1;
        issue(1'b0, 15'h0000, 8'h00);
        chk("rb_stb_bus1", 32'(wb_if.wb_stb_o), 32'h1);
        @(negedge clk_i);
        chk("rb_stb_bus2", 32'(wb_if.wb_stb_o), 32'h1);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rb_cyc", 32'(wb_if.wb_cyc_o), 32'h0);
        chk("rb_stb", 32'(wb_if.wb_stb_o), 32'h0);
        chk("rb_busy", 32'(cpu_busy_o), 32'h0);
        rst_i      = 1'b0;
        slave_mode = 0;
        observe(4, stb_n, done_n, err_n, err_d, dat_d);
        chk("rb_no_done", 32'(done_n), 32'd0);
        wb_if.wb_dat_i = 32'h44332211;
        issue(1'b0, 15'h0003, 8'h00);
        observe(6, stb_n, done_n, err_n, err_d, dat_d);
        chk("rb_next_done", 32'(done_n), 32'd1);
        chk("rb_next_err",  32'(err_n), 32'd0);
        chk("rb_next_dat",  32'(dat_d), 32'h44);

        // Ack on the timeout cycle: ack wins
        slave_mode = 2;
        issue(1'b0, 15'h0002, 8'h00);
        observe(20, stb_n, done_n, err_n, err_d, dat_d);
        chk("tie_stb_cycles", 32'(stb_n), 32'd16);
        chk("tie_done_cnt",   32'(done_n), 32'd1);
        chk("tie_err_cnt",    32'(err_n), 32'd0);
        chk("tie_dat",        32'(dat_d), 32'h33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_byte_master.md
WB_BYTE_MASTER -- requirements
Module: wb_byte_master

Interface
REQ-001 Parameter: aw, 15, address width in bits for cpu_adr_i and wb_adr_o.
REQ-002 Parameter: timeout, 16, maximum strobe cycles allowed without ack; legal range 1..255.
REQ-003 Port: clk_i  in  1  single clock; all logic on rising edge.
REQ-004 Port: rst_i  in  1  reset, synchronous, active-high.
REQ-005 Port: cpu_req_i  in  1  request a byte transfer; sampled only while cpu_busy_o=0.
REQ-006 Port: cpu_we_i  in  1  1=write, 0=read; sampled with cpu_req_i.
REQ-007 Port: cpu_adr_i  in  aw  byte address; sampled with cpu_req_i.
REQ-008 Port: cpu_dat_i  in  8  write byte; sampled with cpu_req_i.
REQ-009 Port: cpu_dat_o  out  8  last read byte; holds value between reads.
REQ-010 Port: cpu_busy_o  out  1  transfer in progress; requests ignored while high.
REQ-011 Port: cpu_done_o  out  1  one-cycle pulse at completion.
REQ-012 Port: cpu_err_o  out  1  one-cycle pulse with cpu_done_o when the transfer timed out.
REQ-013 Port: wb_adr_o  out  aw  word address = {latched adr[aw-1:2], 2'b00}.
REQ-014 Port: wb_dat_o  out  32  write byte replicated on all four lanes.
REQ-015 Port: wb_dat_i  in  32  read data.
REQ-016 Port: wb_sel_o  out  4  one-hot byte select = 4'b0001 << latched adr[1:0].
REQ-017 Port: wb_we_o, wb_stb_o, wb_cyc_o  out  1 each  Wishbone write-enable, strobe, cycle.
REQ-018 Port: wb_ack_i  in  1  Wishbone acknowledge.

Function
REQ-019 The FSM SHALL have exactly three states, IDLE, BUS and DONE; reset enters IDLE.
REQ-020 In IDLE with cpu_req_i=1, the block SHALL latch we/adr/dat and enter BUS on the next edge; cpu_busy_o SHALL be 1 from that edge.
REQ-021 In BUS, wb_cyc_o and wb_stb_o SHALL both be 1, and wb_adr_o/wb_sel_o/wb_we_o/wb_dat_o SHALL be stable.
REQ-022 In BUS, a cycle counter SHALL start at 0 on entry and increment each BUS cycle without ack.
REQ-023 If wb_ack_i=1 in BUS, the block SHALL enter DONE on that edge.
REQ-024 On that ack edge, if the transfer is a read, cpu_dat_o SHALL load wb_dat_i byte lane adr[1:0]: lane 0=[7:0], 1=[15:8], 2=[23:16], 3=[31:24].
REQ-025 If the counter reaches timeout-1 with wb_ack_i=0, the block SHALL enter DONE with an error flag set.
REQ-026 On timeout of a read, cpu_dat_o SHALL load 8'hFF; on timeout of a write, cpu_dat_o SHALL be unchanged.
REQ-027 If ack and timeout coincide on the same cycle, ack SHALL win and no error SHALL be flagged.
REQ-028 wb_cyc_o and wb_stb_o SHALL be 0 in IDLE and DONE, guaranteeing at least two idle strobe cycles between transfers.
REQ-029 In DONE, cpu_done_o SHALL be 1 and cpu_err_o SHALL equal the error flag for exactly one cycle; then the FSM returns to IDLE.
REQ-030 cpu_busy_o SHALL be 1 in BUS and DONE, and 0 in IDLE.
REQ-031 Minimum latency SHALL be 4 cycles from request accept to the next accept, given a registered-ack slave: accept edge, BUS, BUS(ack), DONE.
REQ-032 wb_ack_i in IDLE or DONE SHALL be ignored.
REQ-033 cpu_req_i held high SHALL start a new transfer on each return to IDLE.
REQ-034 A write SHALL never modify cpu_dat_o.

Reset
REQ-035 With rst_i=1 at an edge, the block SHALL enter IDLE and clear wb_cyc_o, wb_stb_o, wb_we_o, cpu_busy_o, cpu_done_o, cpu_err_o, the error flag and the counter.
REQ-036 Reset SHALL set cpu_dat_o=8'h00, wb_adr_o=0, wb_sel_o=4'b0001 and wb_dat_o=0.
REQ-037 Reset during BUS SHALL drop cyc/stb on the same edge and SHALL generate no cpu_done_o pulse.

Verification
REQ-038 Write adr=15'h0007, dat=8'hA5 to a registered-ack slave -> wb_adr_o=15'h0004, wb_sel_o=4'b1000, wb_dat_o=32'hA5A5A5A5, wb_we_o=1, stb for 2 cycles, one cpu_done_o, cpu_err_o=0.
REQ-039 Read adr=15'h0001 with slave returning 32'h44332211 -> wb_sel_o=4'b0010, cpu_dat_o=8'h22 at done, value held afterwards.
REQ-040 Read to a non-responding slave with timeout=16 -> stb high exactly 16 cycles, then cpu_done_o=cpu_err_o=1 for one cycle, cpu_dat_o=8'hFF.
REQ-041 Back-to-back reads with cpu_req_i held high -> accepts 4 cycles apart, with stb low for at least 2 cycles between transfers.
REQ-042 rst_i asserted on the second BUS cycle -> cyc/stb=0 on the next edge, no done pulse, and the next request proceeds normally.
REQ-043 Ack arriving on the timeout cycle -> cpu_err_o=0 and read data captured from wb_dat_i.
